// File: rtl/proc_en_gen.sv
// Processor-enable generator: per column word, flags which processors see a valid
// patch end-column, derived from runtime patch size, stride and image width.
module proc_en_gen #(
  parameter int NUM_PROC = 8,
  parameter int PW       = 3,
  parameter int IW       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PW-1:0]       patch_size,
  input  logic [PW-1:0]       stride,
  input  logic [IW-1:0]       img_width,
  input  logic                word_strobe,
  input  logic                done,
  output logic [NUM_PROC-1:0] p_en,
  output logic [NUM_PROC-1:0] p_en_rmu,
  output logic                p_en_valid,
  output logic                row_end,
  output logic                busy,
  output logic                cfg_err
);

  localparam int CW = IW + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_r;
  logic [PW-1:0]       k_r;
  logic [PW-1:0]       s_r;
  logic [IW-1:0]       w_r;
  logic [CW-1:0]       col_base_r;
  logic [CW-1:0]       next_end_r;
  logic                done_seen_r;
  logic [NUM_PROC-1:0] p_en_r;
  logic [NUM_PROC-1:0] p_en_rmu_r;
  logic                p_en_valid_r;
  logic                row_end_r;
  logic                busy_r;
  logic                cfg_err_r;

  logic [NUM_PROC-1:0] mask_s;
  logic [CW-1:0]       pos_s;
  logic [CW-1:0]       col_s;
  logic                cfg_bad_s;
  logic                wrap_s;
  logic [CW-1:0]       first_end_s;
  logic [CW-1:0]       start_end_s;

  // Walk the valid end-columns through the word in steps of S; pos_s leaves as the next end.
  always_comb begin
    mask_s = '0;
    pos_s  = next_end_r;
    col_s  = col_base_r;
    for (int i = 0; i < NUM_PROC; i++) begin
      col_s = col_base_r + CW'(i);
      if (col_s == pos_s) begin
        mask_s[i] = (col_s < {1'b0, w_r});
        pos_s     = pos_s + CW'(s_r);
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Config sanity check on the raw inputs and row bookkeeping.
  always_comb begin
    cfg_bad_s   = (patch_size == {PW{1'b0}}) || (stride == {PW{1'b0}}) ||
                  (stride > patch_size) || (IW'(patch_size) > img_width);
    wrap_s      = (col_base_r + CW'(NUM_PROC)) >= {1'b0, w_r};
    first_end_s = CW'(k_r) - CW'(1);
    start_end_s = CW'(patch_size) - CW'(1);
  end

  // Frame FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      k_r          <= '0;
      s_r          <= '0;
      w_r          <= '0;
      col_base_r   <= '0;
      next_end_r   <= '0;
      done_seen_r  <= 1'b0;
      p_en_r       <= '0;
      p_en_rmu_r   <= '0;
      p_en_valid_r <= 1'b0;
      row_end_r    <= 1'b0;
      busy_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      p_en_valid_r <= 1'b0;
      row_end_r    <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            k_r         <= patch_size;
            s_r         <= stride;
            w_r         <= img_width;
            done_seen_r <= 1'b0;
            p_en_r      <= '0;
            p_en_rmu_r  <= '0;
            if (cfg_bad_s) begin
              cfg_err_r <= 1'b1;
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
            end else begin
              cfg_err_r  <= 1'b0;
              col_base_r <= '0;
              next_end_r <= start_end_s;
              state_r    <= ST_RUN;
              busy_r     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (word_strobe) begin
            p_en_r       <= mask_s;
            p_en_rmu_r   <= (done_seen_r || done) ? {NUM_PROC{1'b0}} : mask_s;
            p_en_valid_r <= 1'b1;
            if (wrap_s) begin
              row_end_r  <= 1'b1;
              col_base_r <= '0;
              next_end_r <= first_end_s;
            end else begin
              col_base_r <= col_base_r + CW'(NUM_PROC);
              next_end_r <= pos_s;
            end
          end
          // done wins over the strobe's rmu update; p_en itself is left alone.
          if (done) begin
            done_seen_r <= 1'b1;
            p_en_rmu_r  <= '0;
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign p_en       = p_en_r;
  assign p_en_rmu   = p_en_rmu_r;
  assign p_en_valid = p_en_valid_r;
  assign row_end    = row_end_r;
  assign busy       = busy_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_proc_en_gen.sv
// Bench for proc_en_gen: table-driven strobes with a scoreboard queue, plus
// hand sequences for config errors, done handling and mid-row reset.
module tb_proc_en_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] patch_size;
  logic [2:0] stride;
  logic [9:0] img_width;
  logic       word_strobe;
  logic       done;
  logic [7:0] p_en;
  logic [7:0] p_en_rmu;
  logic       p_en_valid;
  logic       row_end;
  logic       busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st;
    logic [2:0] k;
    logic [2:0] s;
    logic [9:0] w;
    logic [7:0] en;
    logic       re;
  } vec_t;

  typedef struct {
    logic [7:0] en;
    logic [7:0] rmu;
    logic       re;
  } exp_t;

  vec_t vecs [13];
  exp_t sb_q [$];
  exp_t e_m;

  proc_en_gen #(.NUM_PROC(8), .PW(3), .IW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .patch_size(patch_size), .stride(stride),
    .img_width(img_width), .word_strobe(word_strobe), .done(done), .p_en(p_en),
    .p_en_rmu(p_en_rmu), .p_en_valid(p_en_valid), .row_end(row_end), .busy(busy),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] k, input logic [2:0] s, input logic [9:0] w);
    patch_size = k;
    stride     = s;
    img_width  = w;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic end_frame();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic strobe_exp(input logic [7:0] en, input logic [7:0] rmu, input logic re,
                            input logic with_done);
    exp_t e;
    e.en  = en;
    e.rmu = rmu;
    e.re  = re;
    sb_q.push_back(e);
    word_strobe = 1'b1;
    done        = with_done;
    tick();
    word_strobe = 1'b0;
    done        = 1'b0;
  endtask

  task automatic strobe_raw();
    word_strobe = 1'b1;
    tick();
    word_strobe = 1'b0;
  endtask

  // Scoreboard: every p_en_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (p_en_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: p_en=%b, expected no update", p_en);
      end else begin
        e_m = sb_q.pop_front();
        cmp("p_en", p_en, e_m.en);
        cmp("p_en_rmu", p_en_rmu, e_m.rmu);
        cmp("row_end", {7'd0, row_end}, {7'd0, e_m.re});
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 3'd1, 10'd16, 8'b11111100, 1'b0};
    vecs[1]  = '{1'b0, 3'd3, 3'd1, 10'd16, 8'b11111111, 1'b1};
    vecs[2]  = '{1'b1, 3'd3, 3'd2, 10'd16, 8'b01010100, 1'b0};
    vecs[3]  = '{1'b0, 3'd3, 3'd2, 10'd16, 8'b01010101, 1'b1};
    vecs[4]  = '{1'b0, 3'd3, 3'd2, 10'd16, 8'b01010100, 1'b0};
    vecs[5]  = '{1'b1, 3'd5, 3'd3, 10'd20, 8'b10010000, 1'b0};
    vecs[6]  = '{1'b0, 3'd5, 3'd3, 10'd20, 8'b00100100, 1'b0};
    vecs[7]  = '{1'b0, 3'd5, 3'd3, 10'd20, 8'b00001001, 1'b1};
    vecs[8]  = '{1'b1, 3'd1, 3'd1, 10'd8,  8'b11111111, 1'b1};
    vecs[9]  = '{1'b1, 3'd7, 3'd7, 10'd7,  8'b01000000, 1'b1};
    vecs[10] = '{1'b0, 3'd7, 3'd7, 10'd7,  8'b01000000, 1'b1};
    vecs[11] = '{1'b1, 3'd2, 3'd1, 10'd10, 8'b11111110, 1'b0};
    vecs[12] = '{1'b0, 3'd2, 3'd1, 10'd10, 8'b00000011, 1'b1};

    rst = 1'b0; start = 1'b0; patch_size = 3'd0; stride = 3'd0; img_width = 10'd0;
    word_strobe = 1'b0; done = 1'b0;
    repeat (2) tick();
    cmp("rst_p_en", p_en, 8'h00);
    cmp("rst_p_en_rmu", p_en_rmu, 8'h00);
    cmp("rst_flags", {4'd0, p_en_valid, row_end, busy, cfg_err}, 8'h00);
    rst = 1'b1;
    tick();

    // Strobe while idle must be ignored.
    strobe_raw();
    tick();
    cmp("idle_strobe", p_en, 8'h00);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].st) begin
        end_frame();
        do_start(vecs[i].k, vecs[i].s, vecs[i].w);
        cmp("start_busy", {6'd0, busy, cfg_err}, 8'b10);
      end
      strobe_exp(vecs[i].en, vecs[i].en, vecs[i].re, 1'b0);
    end
    tick();
    cmp("hold_p_en", p_en, 8'b00000011);
    cmp("hold_valid", {7'd0, p_en_valid}, 8'h00);

    // Configuration errors.
    end_frame();
    do_start(3'd3, 3'd4, 10'd16);
    cmp("err_s_gt_k", {6'd0, busy, cfg_err}, 8'b01);
    cmp("err_p_en_cleared", p_en, 8'h00);
    strobe_raw();
    tick();
    cmp("err_strobe_ignored", p_en, 8'h00);
    do_start(3'd0, 3'd1, 10'd16);
    cmp("err_k0", {6'd0, busy, cfg_err}, 8'b01);
    do_start(3'd5, 3'd1, 10'd4);
    cmp("err_k_gt_w", {6'd0, busy, cfg_err}, 8'b01);
    do_start(3'd3, 3'd1, 10'd16);
    cmp("err_cleared", {6'd0, busy, cfg_err}, 8'b10);

    // Start during RUN is ignored; done together with the second word.
    do_start(3'd3, 3'd4, 10'd16);
    cmp("run_start_ignored", {6'd0, busy, cfg_err}, 8'b10);
    strobe_exp(8'b11111100, 8'b11111100, 1'b0, 1'b0);
    strobe_exp(8'b11111111, 8'b00000000, 1'b1, 1'b1);
    tick();
    cmp("done_busy", {7'd0, busy}, 8'h00);
    cmp("done_rmu", p_en_rmu, 8'h00);
    strobe_raw();
    tick();
    cmp("done_strobe_p_en", p_en, 8'hFF);
    cmp("done_strobe_rmu", p_en_rmu, 8'h00);

    // Reset mid-row, then a fresh frame restarts at column 0.
    do_start(3'd3, 3'd1, 10'd16);
    strobe_exp(8'b11111100, 8'b11111100, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cmp("mid_rst_p_en", p_en, 8'h00);
    cmp("mid_rst_rmu", p_en_rmu, 8'h00);
    cmp("mid_rst_flags", {4'd0, p_en_valid, row_end, busy, cfg_err}, 8'h00);
    do_start(3'd3, 3'd1, 10'd16);
    strobe_exp(8'b11111100, 8'b11111100, 1'b0, 1'b0);
    repeat (3) tick();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_en_gen.md
Name: proc_en_gen

Overview:
- Parametrised successor to the fixed-table processor-enable generator.
- Computes, per incoming column word, which of NUM_PROC convolution processors hold a valid patch end-column. Validity is derived arithmetically from runtime patch_size, stride and img_width, not from per-combination tables.
- Sits between the column-word sequencer (word_strobe) and the processor array / RMU.
- Adds a frame FSM, row wrap, configuration checking and a sticky done mask for the RMU copy.

Parameters:
- NUM_PROC, 8, number of processors = columns per word; output mask width.
- PW, 3, width of patch_size and stride.
- IW, 10, width of img_width and internal column counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse; latch config and begin a frame (IDLE or DONE only).
- patch_size  in  PW  patch edge length K, sampled on start.
- stride  in  PW  stride S, sampled on start.
- img_width  in  IW  image row width W in columns, sampled on start.
- word_strobe  in  1  one new column word available (columns col_base..col_base+NUM_PROC-1).
- done  in  1  pulse from RMU; end of useful data.
- p_en  out  NUM_PROC  processor enable; bit i = column col_base+i.
- p_en_rmu  out  NUM_PROC  p_en masked to zero once done has been seen.
- p_en_valid  out  1  one-cycle pulse when p_en/p_en_rmu update.
- row_end  out  1  one-cycle pulse with the last word of a row.
- busy  out  1  high in RUN.
- cfg_err  out  1  sticky config error; cleared by the next accepted start.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; p_en=0, p_en_rmu=0, p_en_valid=0, row_end=0, busy=0, cfg_err=0, done_seen=0, col_base=0, next_end=0. Reset mid-frame aborts immediately.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: latch K, S, W. Clear done_seen, p_en, p_en_rmu.
  - If K==0 or S==0 or S>K or K>W: set cfg_err=1 and go to (or stay in) IDLE.
  - Otherwise: cfg_err=0, col_base=0, next_end=K-1, go to RUN.
- RUN + word_strobe, registered, 1-cycle latency:
  - Column c=col_base+i is valid iff c>=K-1, (c-(K-1)) mod S == 0, and c<W.
  - Implement by stepping from next_end in increments of S within the word. No divider.
  - Next edge: p_en=mask, p_en_rmu=mask (or 0 if done_seen or done this cycle), p_en_valid=1.
  - next_end advances to the first valid end >= col_base+NUM_PROC; col_base += NUM_PROC.
  - If col_base+NUM_PROC >= W: row_end=1, col_base=0, next_end=K-1 (new row, same config).
- Between strobes p_en and p_en_rmu hold their values; p_en_valid and row_end are 0.
- word_strobe outside RUN is ignored: no output change.
- start during RUN is ignored.
- done in RUN: done_seen=1, go to DONE, busy=0. p_en is unaffected; p_en_rmu is forced 0 on the same edge.
- done and word_strobe in the same cycle: the word is processed (p_en updated, p_en_valid=1), p_en_rmu=0.
- In DONE, p_en_rmu stays 0 until start.
- Arithmetic: internal columns use IW+1 bits so col_base+NUM_PROC never wraps. Columns >= W are always masked (partial last word).

Test Plan:
- NUM_PROC=8, K=3, S=1, W=16, start, 2 strobes -> p_en=8'b11111100, then 8'hFF with row_end=1; p_en_valid pulses one cycle after each strobe.
- K=3, S=2, W=16 -> word0 8'b01010100, word1 8'b01010101, row_end on word1; a third strobe gives 8'b01010100 again (row wrap).
- K=5, S=3, W=20, 3 strobes -> 8'b10010000, 8'b00100100, 8'b00001001 with row_end=1 (cols 20-23 masked).
- K=3, S=4, start -> cfg_err=1, busy=0, later strobes leave p_en=0. Then a valid start clears cfg_err.
- K=3, S=1, W=16: done in the same cycle as word1's strobe -> p_en=8'hFF, p_en_rmu=0, state DONE. Further strobes are ignored.
- rst=0 asserted mid-row after word0 -> all outputs 0, IDLE. A new start then yields 8'b11111100 on the first strobe.
